// File: rtl/es_alu_pkg.sv
// Shared encodings for the expression stack and its ALU: stack ops, ALU ops
// and fault codes.
package es_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_ALU  = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_OVF  = 2'd1;
    localparam logic [1:0] FAULT_UNF  = 2'd2;

endpackage

// File: rtl/alu_unit_param.sv
// Combinational ALU computing b op a, where a is the stack top and b the
// entry below it, plus signed overflow for ADD/SUB.
module alu_unit_param
    import es_alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] result,
    output logic              ovflw
);

    localparam int SW = $clog2(DATA_W);

    logic [DATA_W-1:0] add_r;
    logic [DATA_W-1:0] sub_r;
    logic              slt;

    assign add_r = b + a;
    assign sub_r = b - a;
    assign slt   = $signed(b) < $signed(a);

    always_comb begin
        result = '0;
        ovflw  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = add_r;
                ovflw  = (a[DATA_W-1] == b[DATA_W-1]) && (add_r[DATA_W-1] != b[DATA_W-1]);
            end
            ALU_SUB: begin
                result = sub_r;
                ovflw  = (a[DATA_W-1] != b[DATA_W-1]) && (sub_r[DATA_W-1] != b[DATA_W-1]);
            end
            ALU_AND: result = b & a;
            ALU_OR:  result = b | a;
            ALU_XOR: result = b ^ a;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt};
            ALU_SHL: result = b << a[SW-1:0];
            default: result = b >> a[SW-1:0];
        endcase
    end

endmodule

// File: rtl/es_alu_stack_param.sv
// DEPTH-entry expression stack with fused ALU, depth/full/empty reporting
// and a sticky first-fault register.
module es_alu_stack_param
    import es_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_act,
    input  logic [2:0]        es_op,
    input  logic [1:0]        pop_amt,
    input  logic [1:0]        dup_amt,
    input  logic              stack_src,
    input  logic [DATA_W-1:0] val_in,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] top_a,
    output logic [DATA_W-1:0] top_b,
    output logic              zero_out,
    output logic              ovflw_out,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic              zero_q, zero_d;
    logic              ovflw_q, ovflw_d;
    logic              fault_q, fault_d;
    logic [1:0]        code_q, code_d;

    logic [AW-1:0]     idx_a, idx_b, idx_push, idx_dup;
    logic [CNT_W-1:0]  pop_n;
    logic              is_full, is_empty;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [1:0]        flt;

    assign is_full  = (depth_q == CNT_W'(DEPTH));
    assign is_empty = (depth_q == '0);
    assign idx_a    = AW'(depth_q - CNT_W'(1));
    assign idx_b    = AW'(depth_q - CNT_W'(2));
    assign idx_push = AW'(depth_q);
    assign idx_dup  = AW'(depth_q - CNT_W'(1) - CNT_W'(dup_amt));
    assign pop_n    = CNT_W'(pop_amt) + CNT_W'(1);

    // Depth gating keeps stale storage invisible after reset or pops.
    assign top_a = is_empty ? '0 : mem_q[idx_a];
    assign top_b = (depth_q < CNT_W'(2)) ? '0 : mem_q[idx_b];

    alu_unit_param #(.DATA_W(DATA_W)) u_alu (
        .a      (top_a),
        .b      (top_b),
        .alu_op (alu_op),
        .result (alu_res),
        .ovflw  (alu_ovf)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        mem_d   = mem_q;
        depth_d = depth_q;
        zero_d  = zero_q;
        ovflw_d = ovflw_q;
        fault_d = fault_q;
        code_d  = code_q;
        flt     = FAULT_NONE;
        if (es_act) begin
            case (es_op)
                OP_PUSH: begin
                    if (is_full) begin
                        flt = FAULT_OVF;
                    end else begin
                        mem_d[idx_push] = stack_src ? alu_res : val_in;
                        depth_d         = depth_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (depth_q < pop_n) flt = FAULT_UNF;
                    else                 depth_d = depth_q - pop_n;
                end
                OP_DUP: begin
                    if (depth_q <= CNT_W'(dup_amt)) begin
                        flt = FAULT_UNF;
                    end else if (is_full) begin
                        flt = FAULT_OVF;
                    end else begin
                        mem_d[idx_push] = mem_q[idx_dup];
                        depth_d         = depth_q + CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    if (depth_q < CNT_W'(2)) begin
                        flt = FAULT_UNF;
                    end else begin
                        mem_d[idx_a] = mem_q[idx_b];
                        mem_d[idx_b] = mem_q[idx_a];
                    end
                end
                OP_ALU: begin
                    if (depth_q < CNT_W'(2)) begin
                        flt = FAULT_UNF;
                    end else begin
                        mem_d[idx_b] = alu_res;
                        depth_d      = depth_q - CNT_W'(1);
                        zero_d       = (alu_res == '0);
                        ovflw_d      = alu_ovf;
                    end
                end
                default: ;
            endcase
        end
        // Only the first fault is latched; later ones leave the code alone.
        if ((flt != FAULT_NONE) && !fault_q) begin
            fault_d = 1'b1;
            code_d  = flt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            zero_q  <= 1'b0;
            ovflw_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FAULT_NONE;
        end else begin
            depth_q <= depth_d;
            zero_q  <= zero_d;
            ovflw_q <= ovflw_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // NOTE: storage is deliberately not reset; depth_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign alu_out    = alu_res;
    assign zero_out   = zero_q;
    assign ovflw_out  = ovflw_q;
    assign depth      = depth_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_es_alu_stack_param.sv
// Self-checking bench: queue-based stack model compared every cycle, plus
// hand-computed literal checks at key points of the directed sequence.
module tb_es_alu_stack_param;
    import es_alu_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam longint SMAX = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (DATA_W - 1));

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              es_act = 1'b0;
    logic [2:0]        es_op = OP_NOP;
    logic [1:0]        pop_amt = '0;
    logic [1:0]        dup_amt = '0;
    logic              stack_src = 1'b0;
    logic [DATA_W-1:0] val_in = '0;
    logic [2:0]        alu_op = ALU_ADD;
    logic [DATA_W-1:0] alu_out, top_a, top_b;
    logic              zero_out, ovflw_out, full, empty, fault;
    logic [CNT_W-1:0]  depth;
    logic [1:0]        fault_code;

    es_alu_stack_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .es_act     (es_act),
        .es_op      (es_op),
        .pop_amt    (pop_amt),
        .dup_amt    (dup_amt),
        .stack_src  (stack_src),
        .val_in     (val_in),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .top_a      (top_a),
        .top_b      (top_b),
        .zero_out   (zero_out),
        .ovflw_out  (ovflw_out),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (top of stack = back of queue) ----------------
    logic [DATA_W-1:0] mdl[$];
    logic              m_zero = 1'b0, m_ovf = 1'b0, m_fault = 1'b0;
    logic [1:0]        m_code = 2'd0;

    function automatic logic [DATA_W-1:0] m_entry(input int i);
        return (mdl.size() > i) ? mdl[mdl.size() - 1 - i] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] m_alu(input logic [2:0] op, input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] a, output logic ovf);
        longint sb, sa, s;
        logic [DATA_W-1:0] r;
        sb  = longint'($signed(b));
        sa  = longint'($signed(a));
        ovf = 1'b0;
        s   = 0;
        case (op)
            3'd0: begin s = sb + sa; r = DATA_W'(s); ovf = (s > SMAX) || (s < SMIN); end
            3'd1: begin s = sb - sa; r = DATA_W'(s); ovf = (s > SMAX) || (s < SMIN); end
            3'd2: r = b & a;
            3'd3: r = b | a;
            3'd4: r = b ^ a;
            3'd5: r = (sb < sa) ? DATA_W'(1) : DATA_W'(0);
            3'd6: r = b << (int'(a) % DATA_W);
            default: r = b >> (int'(a) % DATA_W);
        endcase
        return r;
    endfunction

    task automatic m_step();
        int code;
        int n;
        logic ov;
        logic [DATA_W-1:0] a, b, r;
        code = 0;
        case (es_op)
            3'd1: begin
                if (mdl.size() == DEPTH) code = 1;
                else begin
                    r = stack_src ? m_alu(alu_op, m_entry(1), m_entry(0), ov) : val_in;
                    mdl.push_back(r);
                end
            end
            3'd2: begin
                n = int'(pop_amt) + 1;
                if (mdl.size() < n) code = 2;
                else repeat (n) void'(mdl.pop_back());
            end
            3'd3: begin
                if (mdl.size() <= int'(dup_amt)) code = 2;
                else if (mdl.size() == DEPTH)    code = 1;
                else begin
                    r = m_entry(int'(dup_amt));
                    mdl.push_back(r);
                end
            end
            3'd4: begin
                if (mdl.size() < 2) code = 2;
                else begin
                    a = mdl.pop_back();
                    b = mdl.pop_back();
                    mdl.push_back(a);
                    mdl.push_back(b);
                end
            end
            3'd5: begin
                if (mdl.size() < 2) code = 2;
                else begin
                    a = mdl.pop_back();
                    b = mdl.pop_back();
                    r = m_alu(alu_op, b, a, ov);
                    mdl.push_back(r);
                    m_zero = (r == '0);
                    m_ovf  = ov;
                end
            end
            default: ;
        endcase
        if (code != 0 && !m_fault) begin
            m_fault = 1'b1;
            m_code  = 2'(code);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mdl.delete();
            m_zero = 1'b0; m_ovf = 1'b0; m_fault = 1'b0; m_code = 2'd0;
        end else if (es_act) begin
            m_step();
        end
    end

    // Compare process: outputs checked 1 time unit after every active edge.
    always @(posedge clk) begin
        logic ov;
        #1;
        if (cmp_en) begin
            check("cmp_depth", 32'(depth), 32'(mdl.size()));
            check("cmp_top_a", 32'(top_a), 32'(m_entry(0)));
            check("cmp_top_b", 32'(top_b), 32'(m_entry(1)));
            check("cmp_full", 32'(full), 32'(mdl.size() == DEPTH));
            check("cmp_empty", 32'(empty), 32'(mdl.size() == 0));
            check("cmp_zero", 32'(zero_out), 32'(m_zero));
            check("cmp_ovflw", 32'(ovflw_out), 32'(m_ovf));
            check("cmp_fault", 32'(fault), 32'(m_fault));
            check("cmp_code", 32'(fault_code), 32'(m_code));
            check("cmp_alu_out", 32'(alu_out), 32'(m_alu(alu_op, m_entry(1), m_entry(0), ov)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input logic [2:0] op, input logic [1:0] pa = 2'd0, input logic [1:0] da = 2'd0,
                         input logic src = 1'b0, input logic [DATA_W-1:0] v = '0,
                         input logic [2:0] aop = ALU_ADD);
        es_act = 1'b1; es_op = op; pop_amt = pa; dup_amt = da;
        stack_src = src; val_in = v; alu_op = aop;
        @(posedge clk);
        #2;
        es_act = 1'b0; es_op = OP_NOP; stack_src = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        do_op(OP_PUSH, 2'd0, 2'd0, 1'b0, v, ALU_ADD);
    endtask

    task automatic alu(input logic [2:0] aop);
        do_op(OP_ALU, 2'd0, 2'd0, 1'b0, '0, aop);
    endtask

    task automatic do_reset(input logic with_push);
        reset = 1'b1;
        es_act = with_push; es_op = with_push ? OP_PUSH : OP_NOP; val_in = 16'h00AA;
        @(posedge clk);
        #2;
        reset = 1'b0; es_act = 1'b0; es_op = OP_NOP;
    endtask

    typedef struct {
        logic [2:0]        op;
        logic [DATA_W-1:0] exp;
    } alu_vec_t;

    alu_vec_t vecs[8] = '{
        '{ALU_ADD, 16'h8008}, '{ALU_SUB, 16'h8002}, '{ALU_AND, 16'h0001}, '{ALU_OR,  16'h8007},
        '{ALU_XOR, 16'h8006}, '{ALU_SLT, 16'h0001}, '{ALU_SHL, 16'h0028}, '{ALU_SHR, 16'h1000}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        do_reset(1'b0);
        cmp_en = 1'b1;
        check("lit_reset_depth", 32'(depth), 32'd0);
        check("lit_reset_empty", 32'(empty), 32'd1);

        // Basic ADD
        push(16'd1); push(16'd2); alu(ALU_ADD);
        check("lit_add_depth", 32'(depth), 32'd1);
        check("lit_add_top", 32'(top_a), 32'd3);
        check("lit_add_zero", 32'(zero_out), 32'd0);
        check("lit_add_fault", 32'(fault), 32'd0);

        // Signed overflow, then SUB to zero without overflow
        push(16'h7FFF); push(16'h0001); alu(ALU_ADD);
        check("lit_ovf_top", 32'(top_a), 32'h8000);
        check("lit_ovf_flag", 32'(ovflw_out), 32'd1);
        push(16'h8000); alu(ALU_SUB);
        check("lit_sub_top", 32'(top_a), 32'd0);
        check("lit_sub_zero", 32'(zero_out), 32'd1);
        check("lit_sub_ovf", 32'(ovflw_out), 32'd0);

        // Each ALU op on B=0x8005, A=0x0003
        foreach (vecs[i]) begin
            push(16'h8005); push(16'h0003); alu(vecs[i].op);
            check($sformatf("lit_alu_op%0d", vecs[i].op), 32'(top_a), 32'(vecs[i].exp));
            do_op(OP_POP);
        end

        // Fill, overflow, sticky first code across a later underflow
        do_reset(1'b0);
        for (int i = 1; i <= DEPTH; i++) push(DATA_W'(i));
        check("lit_full", 32'(full), 32'd1);
        push(16'd99);
        check("lit_ovf_depth", 32'(depth), 32'(DEPTH));
        check("lit_ovf_top_kept", 32'(top_a), 32'd16);
        check("lit_ovf_code", 32'(fault_code), 32'd1);
        do_op(OP_POP, 2'd3);
        check("lit_pop4_depth", 32'(depth), 32'd12);
        check("lit_pop4_top", 32'(top_a), 32'd12);
        check("lit_pop4_fault", 32'(fault), 32'd1);
        repeat (3) do_op(OP_POP, 2'd3);
        check("lit_pop_exact_empty", 32'(empty), 32'd1);
        do_op(OP_POP, 2'd0);
        check("lit_sticky_code", 32'(fault_code), 32'd1);

        // DUP and SWAP
        do_reset(1'b0);
        push(16'd5); push(16'd6); push(16'd7);
        do_op(OP_DUP, 2'd0, 2'd2);
        check("lit_dup_depth", 32'(depth), 32'd4);
        check("lit_dup_top_a", 32'(top_a), 32'd5);
        check("lit_dup_top_b", 32'(top_b), 32'd7);
        do_op(OP_SWAP);
        check("lit_swap_top_a", 32'(top_a), 32'd7);
        check("lit_swap_top_b", 32'(top_b), 32'd5);
        do_op(OP_DUP, 2'd0, 2'd3);
        check("lit_dup3_top", 32'(top_a), 32'd5);

        // Underflow on empty and on ALU with one entry; flags preserved
        do_reset(1'b0);
        do_op(OP_POP, 2'd0);
        check("lit_unf_depth", 32'(depth), 32'd0);
        check("lit_unf_code", 32'(fault_code), 32'd2);
        push(16'd5); push(16'd5); alu(ALU_SUB);
        alu(ALU_ADD);
        check("lit_alu_unf_depth", 32'(depth), 32'd1);
        check("lit_alu_unf_zero", 32'(zero_out), 32'd1);
        check("lit_alu_unf_code", 32'(fault_code), 32'd2);
        do_op(OP_SWAP);
        do_op(3'd7);

        // DUP at DEPTH-1 fills the stack; another DUP overflows
        do_reset(1'b0);
        for (int i = 1; i < DEPTH; i++) push(DATA_W'(i));
        do_op(OP_DUP, 2'd0, 2'd0);
        check("lit_dup_full", 32'(full), 32'd1);
        check("lit_dup_full_fault", 32'(fault), 32'd0);
        do_op(OP_DUP, 2'd0, 2'd0);
        check("lit_dup_ovf_code", 32'(fault_code), 32'd1);

        // PUSH of alu_out, then reset beats a concurrent PUSH
        do_reset(1'b0);
        push(16'd3); push(16'd4);
        do_op(OP_PUSH, 2'd0, 2'd0, 1'b1, 16'hFFFF, ALU_SHL);
        check("lit_push_alu_top", 32'(top_a), 32'h30);
        check("lit_push_alu_zero", 32'(zero_out), 32'd0);
        push(16'h7FFF); push(16'h0001); alu(ALU_ADD);
        do_op(OP_POP, 2'd3); do_op(OP_POP, 2'd3);
        check("lit_pre_reset_fault", 32'(fault), 32'd1);
        do_reset(1'b1);
        check("lit_rst_depth", 32'(depth), 32'd0);
        check("lit_rst_empty", 32'(empty), 32'd1);
        check("lit_rst_ovf", 32'(ovflw_out), 32'd0);
        check("lit_rst_fault", 32'(fault), 32'd0);
        check("lit_rst_code", 32'(fault_code), 32'd0);

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/es_alu_stack_param.md
Name: es_alu_stack_param

Overview:
- Parametrised expression-stack plus ALU for the stack processor; successor to the fixed 16-bit expression-stack/ALU pair.
- Holds a DEPTH-entry LIFO of DATA_W-bit words and performs push, multi-pop, dup-N and swap.
- Fused ALU operation pops the two top entries and pushes B op A.
- Sits between the control unit, which drives the op and act strobes, and the datapath value/ALU-result muxing. Adds depth/full/empty reporting and sticky fault detection.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 16, stack capacity in entries (≥4).
- CNT_W, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, reset sampled only on rising clk edge.
- es_act  in  1  commit es_op on this edge; 0 means hold everything.
- es_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ALU; 6–7 reserved and treated as NOP.
- pop_amt  in  2  POP removes pop_amt+1 entries (1–4).
- dup_amt  in  2  DUP pushes a copy of entry index dup_amt (0 = top).
- stack_src  in  1  PUSH source: 0 = val_in, 1 = alu_out.
- val_in  in  DATA_W  external push value.
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SHL, 7 SHR (logical; shift amount = A[$clog2(DATA_W)-1:0]).
- alu_out  out  DATA_W  combinational B op A; A = top, B = second.
- top_a  out  DATA_W  current top entry; 0 when empty.
- top_b  out  DATA_W  current second entry; 0 when depth < 2.
- zero_out  out  1  registered: last committed ALU result == 0.
- ovflw_out  out  1  registered: signed overflow of the last committed ADD/SUB; 0 for other ops.
- depth  out  CNT_W  entry count.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- fault  out  1  sticky stack fault.
- fault_code  out  2  1 overflow, 2 underflow; 0 none. Holds the first fault.

Behaviour:
- Reset (priority over es_act): depth = 0; zero_out, ovflw_out, fault and fault_code = 0. Storage contents are don't-care, but top_a/top_b read 0 via the depth gating.
- Storage: reg array mem[0..DEPTH-1]; entry i from top = mem[depth-1-i].
- All state updates happen on the rising clk edge when es_act = 1. Outputs reflect the new state the cycle after commit (1-cycle latency). alu_out is combinational on the current A/B and alu_op.
- PUSH: if !full, write the selected source to mem[depth] and increment depth. If full: no state change, fault = 1, code 1.
- POP: n = pop_amt+1. If depth ≥ n, depth -= n. Else no change, fault, code 2.
- DUP: requires depth > dup_amt (else underflow) and !full (else overflow). Pushes mem[depth-1-dup_amt].
- SWAP: requires depth ≥ 2 (else underflow). Exchanges the top two entries.
- ALU: requires depth ≥ 2 (else underflow; flags unchanged). On success, mem[depth-2] = alu_out, depth -= 1, zero_out and ovflw_out updated.
- ADD/SUB are modulo 2^DATA_W. Overflow means operand signs agree (for SUB: B sign != A sign) and the result sign differs from B's sign. SLT yields 1/0 zero-extended.
- zero_out/ovflw_out change only on a successful ALU commit; PUSH of alu_out does not update them.
- Faulting op: the stack is untouched. fault stays high and fault_code keeps its first value until reset. Later legal ops still execute.
- NOP or reserved es_op with es_act = 1: no change.
- Reset asserted together with es_act: reset wins and the op is dropped.
- Boundary cases: DUP at depth == DEPTH-1 is legal and makes the stack full. POP of exactly depth entries is legal and leaves the stack empty.

Decomposition:
- Package es_alu_pkg: es_op and alu_op localparam encodings, and fault code constants.
- Sub-module alu_unit_param (combinational, DATA_W-parametrised): inputs a, b, alu_op; outputs result, ovflw. It is instantiated once. Zero detection and flag registers stay in the parent.

Test Plan:
- Reset, PUSH 1, PUSH 2, ALU ADD → depth 1, top_a 3, zero_out 0, ovflw_out 0, fault 0.
- PUSH 0x7FFF, PUSH 0x0001, ALU ADD → top_a 0x8000, ovflw_out 1. Then PUSH 0x8000, ALU SUB → top_a 0, zero_out 1, ovflw_out 0.
- Push 1..16 (DEPTH = 16) → full 1. Then PUSH 99 → depth 16, top_a 16, fault 1, fault_code 1. A subsequent POP pop_amt = 3 → depth 12, top_a 12; fault stays 1.
- PUSH 5, 6, 7; DUP dup_amt = 2 → depth 4, top_a 5, top_b 7. SWAP → top_a 7, top_b 5.
- Empty stack, POP pop_amt = 0 → depth 0, fault_code 2. ALU with depth 1 → depth unchanged, zero_out and ovflw_out unchanged, fault_code remains 2.
- PUSH 4; PUSH with stack_src = 1, alu_op = SHL, A = 4, B = 3 → pushes 0x30. Assert reset with es_act = 1 and PUSH → next cycle depth 0, empty 1, all flags 0.
